// File: rtl/cpu_fetch_prefetch_pkg.sv
// Shared types and helpers for the instruction fetch / prefetch unit.
package pck_fetch;

  // One prefetched bus word together with the word-aligned address it came from.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  // Byte distance between two RV32C halfwords.
  localparam int unsigned C_HALF_BYTES = 2;

  // Low two bits != 2'b11 marks a 16-bit RV32C encoding.
  function automatic logic is_compressed(input logic [15:0] hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries with head and next-entry peek.
module cpu_fetch_fifo
  import pck_fetch::*;
#(
  parameter int unsigned p_depth = 4,
  localparam int unsigned C_PTR_W = $clog2(p_depth),
  localparam int unsigned C_CNT_W = C_PTR_W + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_push_entry,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [C_CNT_W-1:0] o_count,
  output fetch_entry_t       o_head,
  output fetch_entry_t       o_next
);

  localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(p_depth);

  fetch_entry_t               mem [p_depth];
  logic [C_PTR_W-1:0]         wr_ptr;
  logic [C_PTR_W-1:0]         rd_ptr;
  logic [C_PTR_W-1:0]         rd_ptr_nxt;
  logic [C_CNT_W-1:0]         count;
  logic                       do_push;
  logic                       do_pop;

  // Pop is ignored when empty; push on a full queue is only taken alongside a pop.
  always_comb begin
    do_pop     = i_pop && (count != '0);
    do_push    = i_push && ((count != C_FULL) || do_pop);
    rd_ptr_nxt = rd_ptr + 1'b1;
  end

  // Entry storage; data is not reset, validity comes from the count.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) begin
      mem[wr_ptr] <= i_push_entry;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  assign o_count = count;
  assign o_head  = mem[rd_ptr];
  assign o_next  = mem[rd_ptr_nxt];

endmodule

// File: rtl/cpu_fetch_prefetch.sv
// Instruction fetch unit: prefetches words over ibus, realigns RV32C halfword
// streams (including straddling 32-bit instructions) and hands one
// instruction per valid/ready handshake to decode.
module cpu_fetch_prefetch
  import pck_fetch::*;
#(
  parameter logic [31:0] p_reset_vector = 32'hf0000000,
  parameter int unsigned p_depth        = 4,
  parameter bit          p_compressed   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sleep,
  output logic [31:0] ibus_addr,
  output logic        ibus_rd_en,
  output logic        ibus_wr_en,
  output logic [3:0]  ibus_be,
  output logic [31:0] ibus_wr_data,
  input  logic [31:0] ibus_rd_data,
  input  logic        ibus_busy,
  input  logic        ibus_ack,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_compressed
);

  localparam int unsigned        C_CNT_W = $clog2(p_depth) + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(p_depth);
  localparam logic [C_CNT_W-1:0] C_TWO   = C_CNT_W'(2);

  // Request-side state
  logic [31:0]        fetch_addr;
  logic [31:0]        req_addr;
  logic               outstanding;
  logic               discard;
  logic               hold;
  logic               run;

  // Alignment state: which halfword of the head word is current
  logic               h;

  // Queue interface
  logic [C_CNT_W-1:0] count;
  fetch_entry_t       head;
  fetch_entry_t       next;
  fetch_entry_t       push_entry;
  logic               push;
  logic               pop;

  // Decode-side combinational terms
  logic [15:0]        hw;
  logic               comp;
  logic               instr_ok;
  logic               fire;
  logic               accept;
  logic               ack_take;
  logic [31:0]        empty_base;

  logic               unused_pc_bit0;
  logic               unused_next;

  assign unused_pc_bit0 = i_redirect_pc[0];
  assign unused_next    = ^{next.addr, next.data[31:16]};

  // Bus request generation; a busy-stalled request is held even if sleep rises.
  always_comb begin
    ibus_rd_en = run && !outstanding && !i_redirect &&
                 (hold || (!i_sleep && (count < C_DEPTH)));
    accept     = ibus_rd_en && !ibus_busy;
    ack_take   = ibus_ack && outstanding;
    push       = ack_take && !discard && !i_redirect;
  end

  assign ibus_addr    = fetch_addr;
  assign ibus_wr_en   = 1'b0;
  assign ibus_be      = 4'b0000;
  assign ibus_wr_data = 32'h0;

  // Request control: outstanding/discard bookkeeping, fetch address, redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_addr  <= p_reset_vector;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      hold        <= 1'b0;
      run         <= 1'b0;
    end else begin
      run <= 1'b1;
      if (i_redirect) begin
        fetch_addr <= {i_redirect_pc[31:2], 2'b00};
        hold       <= 1'b0;
        if (outstanding && !ibus_ack) begin
          discard <= 1'b1;
        end else begin
          outstanding <= 1'b0;
          discard     <= 1'b0;
        end
      end else begin
        hold <= ibus_rd_en && ibus_busy;
        if (ack_take) begin
          outstanding <= 1'b0;
          discard     <= 1'b0;
        end
        if (accept) begin
          outstanding <= 1'b1;
          fetch_addr  <= fetch_addr + 32'd4;
        end
      end
    end
  end

  // Address of the in-flight read, tagged onto the word when it returns.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      req_addr <= fetch_addr;
    end
  end

  assign push_entry = '{addr: req_addr, data: ibus_rd_data};

  cpu_fetch_fifo #(
    .p_depth (p_depth)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (push),
    .i_push_entry (push_entry),
    .i_pop        (pop),
    .i_flush      (i_redirect),
    .o_count      (count),
    .o_head       (head),
    .o_next       (next)
  );

  // Instruction realignment from the head (and next, for straddles) word.
  always_comb begin
    hw       = h ? head.data[31:16] : head.data[15:0];
    comp     = p_compressed && is_compressed(hw);
    if (comp || !h) begin
      instr_ok = (count != '0);
    end else begin
      instr_ok = (count >= C_TWO);
    end
    o_instr_valid = instr_ok && !i_redirect;
    fire          = o_instr_valid && i_instr_ready;
    pop           = fire && (!comp || h);

    if (comp) begin
      o_instr = {16'h0000, hw};
    end else if (h) begin
      o_instr = {next.data[15:0], head.data[31:16]};
    end else begin
      o_instr = head.data;
    end
    o_compressed = comp;

    empty_base = (outstanding && !discard) ? req_addr : fetch_addr;
    if (count != '0) begin
      o_pc = head.addr + (h ? 32'(C_HALF_BYTES) : 32'd0);
    end else begin
      o_pc = {empty_base[31:2], h, 1'b0};
    end
  end

  // Halfword offset: advances on compressed consumes, reloads on redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h <= 1'b0;
    end else if (i_redirect) begin
      h <= i_redirect_pc[1];
    end else if (fire && comp) begin
      h <= ~h;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_prefetch.sv
// Directed bench for cpu_fetch_prefetch with a small ibus memory responder.
module tb_cpu_fetch_prefetch;

  logic        clk;
  logic        rst_n;
  logic        sleep;
  logic [31:0] ibus_addr;
  logic        ibus_rd_en;
  logic        ibus_wr_en;
  logic [3:0]  ibus_be;
  logic [31:0] ibus_wr_data;
  logic [31:0] ibus_rd_data;
  logic        ibus_busy;
  logic        ibus_ack;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        compressed;

  logic [31:0] mem [0:255];
  int          ack_lat;
  int          acc_cnt;
  logic [31:0] last_addr;
  logic        pend;
  int          pcnt;
  logic [31:0] pdata;

  int n_checks;
  int n_fails;

  cpu_fetch_prefetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sleep       (sleep),
    .ibus_addr     (ibus_addr),
    .ibus_rd_en    (ibus_rd_en),
    .ibus_wr_en    (ibus_wr_en),
    .ibus_be       (ibus_be),
    .ibus_wr_data  (ibus_wr_data),
    .ibus_rd_data  (ibus_rd_data),
    .ibus_busy     (ibus_busy),
    .ibus_ack      (ibus_ack),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_instr       (instr),
    .o_pc          (pc),
    .o_compressed  (compressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: ack arrives ack_lat cycles after the cycle following acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibus_ack     <= 1'b0;
      ibus_rd_data <= 32'h0;
      pend         <= 1'b0;
      pcnt         <= 0;
      pdata        <= 32'h0;
      acc_cnt      <= 0;
      last_addr    <= 32'h0;
    end else begin
      ibus_ack <= 1'b0;
      if (pend) begin
        if (pcnt == 0) begin
          ibus_ack     <= 1'b1;
          ibus_rd_data <= pdata;
          pend         <= 1'b0;
        end else begin
          pcnt <= pcnt - 1;
        end
      end
      if (ibus_rd_en && !ibus_busy) begin
        acc_cnt   <= acc_cnt + 1;
        last_addr <= ibus_addr;
        if (ack_lat == 0) begin
          ibus_ack     <= 1'b1;
          ibus_rd_data <= mem[ibus_addr[9:2]];
        end else begin
          pend  <= 1'b1;
          pcnt  <= ack_lat - 1;
          pdata <= mem[ibus_addr[9:2]];
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic start();
    rst_n       = 1'b0;
    sleep       = 1'b0;
    ibus_busy   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    clear_mem();
    mem[0] = 32'h00000013;
    ack_lat = 0;
    rst_n = 1'b0;
    sleep = 1'b0; ibus_busy = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ibus_rd_en !== 1'b0) begin n_fails++; $display("FAIL reset_rd_en: got %b expected 0", ibus_rd_en); end
    n_checks++;
    if (ibus_addr !== 32'hf0000000) begin n_fails++; $display("FAIL reset_addr: got %h expected f0000000", ibus_addr); end
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_checks++;
    if (pc !== 32'hf0000000) begin n_fails++; $display("FAIL reset_pc: got %h expected f0000000", pc); end
    n_checks++;
    if ({ibus_wr_en, ibus_be, ibus_wr_data} !== 37'h0) begin n_fails++; $display("FAIL tied_write: got %b %b %h expected zeros", ibus_wr_en, ibus_be, ibus_wr_data); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ibus_rd_en !== 1'b1 || ibus_addr !== 32'hf0000000) begin n_fails++; $display("FAIL first_req: got rd_en=%b addr=%h expected 1 f0000000", ibus_rd_en, ibus_addr); end
    wait_valid(10, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL first_valid: got timeout expected valid"); end
    n_checks++;
    if (instr !== 32'h00000013 || pc !== 32'hf0000000 || compressed !== 1'b0) begin
      n_fails++; $display("FAIL first_instr: got %h@%h c=%b expected 00000013@f0000000 c=0", instr, pc, compressed);
    end
  endtask

  task automatic test_compressed();
    bit ok;
    logic [31:0] ei [3];
    logic [31:0] ep [3];
    logic        ec [3];
    ei = '{32'h00004501, 32'h00004501, 32'h00000013};
    ep = '{32'hf0000000, 32'hf0000002, 32'hf0000004};
    ec = '{1'b1, 1'b1, 1'b0};
    clear_mem();
    mem[0] = 32'h45014501;
    mem[1] = 32'h00000013;
    ack_lat = 0;
    start();
    for (int k = 0; k < 3; k++) begin
      wait_valid(20, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL comp_valid[%0d]: got timeout expected valid", k); end
      n_checks++;
      if (instr !== ei[k] || pc !== ep[k] || compressed !== ec[k]) begin
        n_fails++; $display("FAIL comp_instr[%0d]: got %h@%h c=%b expected %h@%h c=%b", k, instr, pc, compressed, ei[k], ep[k], ec[k]);
      end
      consume();
    end
  endtask

  task automatic test_straddle();
    bit ok;
    clear_mem();
    mem[0] = 32'h00134501;
    mem[1] = 32'h00000000;
    ack_lat = 0;
    start();
    wait_valid(20, ok);
    n_checks++;
    if (!ok || instr !== 32'h00004501 || pc !== 32'hf0000000 || compressed !== 1'b1) begin
      n_fails++; $display("FAIL straddle_cli: got %h@%h c=%b expected 00004501@f0000000 c=1", instr, pc, compressed);
    end
    ibus_busy = 1'b1;
    consume();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (instr_valid !== 1'b0 || ibus_rd_en !== 1'b1 || ibus_addr !== 32'hf0000004) begin
        n_fails++; $display("FAIL straddle_wait[%0d]: got valid=%b rd_en=%b addr=%h expected 0 1 f0000004", k, instr_valid, ibus_rd_en, ibus_addr);
      end
      @(negedge clk);
    end
    ibus_busy = 1'b0;
    wait_valid(20, ok);
    n_checks++;
    if (!ok || instr !== 32'h00000013 || pc !== 32'hf0000002 || compressed !== 1'b0) begin
      n_fails++; $display("FAIL straddle_32: got %h@%h c=%b expected 00000013@f0000002 c=0", instr, pc, compressed);
    end
  endtask

  task automatic test_fill();
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 32'h00000013 | (32'(i) << 7);
    ack_lat = 0;
    start();
    repeat (20) @(negedge clk);
    n_checks++;
    if (acc_cnt !== 4 || ibus_rd_en !== 1'b0) begin n_fails++; $display("FAIL fill_full: got reqs=%0d rd_en=%b expected 4 0", acc_cnt, ibus_rd_en); end
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00000013 || pc !== 32'hf0000000) begin
      n_fails++; $display("FAIL fill_head: got v=%b %h@%h expected 1 00000013@f0000000", instr_valid, instr, pc);
    end
    consume();
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00000093 || pc !== 32'hf0000004) begin
      n_fails++; $display("FAIL fill_second: got v=%b %h@%h expected 1 00000093@f0000004", instr_valid, instr, pc);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (acc_cnt !== 5 || ibus_rd_en !== 1'b0 || last_addr !== 32'hf0000010) begin
      n_fails++; $display("FAIL fill_refill: got reqs=%0d rd_en=%b last=%h expected 5 0 f0000010", acc_cnt, ibus_rd_en, last_addr);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    bit seen;
    clear_mem();
    mem[0]  = 32'h00000013;
    mem[64] = 32'h45050013;
    ack_lat = 3;
    start();
    repeat (2) @(negedge clk);
    n_checks++;
    if (ibus_rd_en !== 1'b0 || acc_cnt !== 1) begin n_fails++; $display("FAIL redir_outstanding: got rd_en=%b reqs=%0d expected 0 1", ibus_rd_en, acc_cnt); end
    redirect    = 1'b1;
    redirect_pc = 32'hf0000102;
    ibus_busy   = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ibus_rd_en) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fails++; $display("FAIL redir_req: got no request expected request"); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ibus_rd_en !== 1'b1 || ibus_addr !== 32'hf0000100 || instr_valid !== 1'b0) begin
        n_fails++; $display("FAIL redir_hold[%0d]: got rd_en=%b addr=%h valid=%b expected 1 f0000100 0", k, ibus_rd_en, ibus_addr, instr_valid);
      end
      @(negedge clk);
    end
    ibus_busy = 1'b0;
    wait_valid(30, ok);
    n_checks++;
    if (!ok || instr !== 32'h00004505 || pc !== 32'hf0000102 || compressed !== 1'b1) begin
      n_fails++; $display("FAIL redir_first: got %h@%h c=%b expected 00004505@f0000102 c=1", instr, pc, compressed);
    end
  endtask

  task automatic test_sleep();
    bit ok;
    clear_mem();
    mem[0] = 32'h45014501;
    mem[1] = 32'h00000013;
    ack_lat = 0;
    start();
    wait_valid(20, ok);
    sleep = 1'b1;
    #1;
    n_checks++;
    if (ibus_rd_en !== 1'b0) begin n_fails++; $display("FAIL sleep_block: got rd_en=%b expected 0", ibus_rd_en); end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00004501 || pc !== (32'hf0000000 + 32'(2 * k)) || ibus_rd_en !== 1'b0) begin
        n_fails++; $display("FAIL sleep_drain[%0d]: got v=%b %h@%h rd_en=%b expected 1 00004501@%h 0", k, instr_valid, instr, pc, ibus_rd_en, 32'hf0000000 + 32'(2 * k));
      end
      consume();
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || ibus_rd_en !== 1'b0 || acc_cnt !== 1) begin
      n_fails++; $display("FAIL sleep_idle: got v=%b rd_en=%b reqs=%0d expected 0 0 1", instr_valid, ibus_rd_en, acc_cnt);
    end
    sleep = 1'b0;
    #1;
    n_checks++;
    if (ibus_rd_en !== 1'b1 || ibus_addr !== 32'hf0000004) begin
      n_fails++; $display("FAIL sleep_wake: got rd_en=%b addr=%h expected 1 f0000004", ibus_rd_en, ibus_addr);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    ack_lat  = 0;
    rst_n = 1'b0; sleep = 1'b0; ibus_busy = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    test_reset();
    test_compressed();
    test_straddle();
    test_fill();
    test_redirect();
    test_sleep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
